// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared op-field positions and FSM state type for the delay timer.
package tmr_pkg;

  localparam int OP_ABORT_BIT    = 3;
  localparam int OP_PERIODIC_BIT = 2;
  localparam int OP_SCALE_LSB    = 0;
  localparam int OP_SCALE_MSB    = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - command/status bundle for timer_ctrl.
// cnt_q exists only when TMR_READBACK_EN is defined.
interface timer_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 48
);

  logic              cs;
  logic [3:0]        op;
  logic [DATA_W-1:0] data_in;
  logic              rdy;
  logic              tick;
`ifdef TMR_READBACK_EN
  logic [CNT_W-1:0]  cnt_q;
`endif

  modport master (
    output cs, op, data_in,
    input  rdy, tick
`ifdef TMR_READBACK_EN
    , input cnt_q
`endif
  );

  modport slave (
    input  cs, op, data_in,
    output rdy, tick
`ifdef TMR_READBACK_EN
    , output cnt_q
`endif
  );

endinterface

// File: rtl/tmr_down_cnt.sv
// rtl/tmr_down_cnt.sv - loadable down counter that holds at zero.
module tmr_down_cnt #(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             ce,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] q,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= value;
    end else if (ce && (q != '0)) begin
      q <= q - CNT_W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable down-count delay timer with prescale, auto-reload and abort.
// TMR_READBACK_EN adds the cnt_q readback of the running count.
module timer_ctrl #(
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 48,
  parameter int SCALE_STEP = 8
) (
  input logic          clk,
  input logic          rst_n,
  timer_ctrl_if.slave  bus
);

  import tmr_pkg::*;

  if (CNT_W < DATA_W + 3 * SCALE_STEP) begin : g_width_chk
    $error("timer_ctrl: CNT_W too small for DATA_W plus maximum prescale shift");
  end

  tmr_state_t       state, next_state;
  logic             rdy_q, tick_q, tick_d;
  logic             periodic_q, periodic_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] scaled;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             load, zero;
  logic             abort_cmd, load_cmd;

  // Prescale: shift the zero-extended count by code*SCALE_STEP, dropping bits beyond CNT_W.
  always_comb begin
    scaled = CNT_W'(bus.data_in) << (int'(bus.op[OP_SCALE_MSB:OP_SCALE_LSB]) * SCALE_STEP);
  end

  assign abort_cmd = bus.cs && bus.op[OP_ABORT_BIT];
  assign load_cmd  = bus.cs && !bus.op[OP_ABORT_BIT];

  tmr_down_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .ce    (state == RUN),
    .value (load_val),
    .q     (cnt),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b1;
      tick_q     <= 1'b0;
      periodic_q <= 1'b0;
      reload_q   <= '0;
    end else begin
      state      <= next_state;
      rdy_q      <= (next_state == IDLE);
      tick_q     <= tick_d;
      periodic_q <= periodic_d;
      reload_q   <= reload_d;
    end
  end

  always_comb begin
    next_state = state;
    tick_d     = 1'b0;
    load       = 1'b0;
    load_val   = scaled;
    periodic_d = periodic_q;
    reload_d   = reload_q;
    case (state)
      IDLE: begin
        if (load_cmd) begin
          load       = 1'b1;
          reload_d   = scaled;
          periodic_d = bus.op[OP_PERIODIC_BIT];
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort_cmd) begin
          load       = 1'b1;
          load_val   = '0;
          periodic_d = 1'b0;
          next_state = IDLE;
        end else if (load_cmd) begin
          // A load landing on an expiry still reports that expiry.
          tick_d     = zero;
          load       = 1'b1;
          reload_d   = scaled;
          periodic_d = bus.op[OP_PERIODIC_BIT];
        end else if (zero) begin
          tick_d = 1'b1;
          if (periodic_q) begin
            load     = 1'b1;
            load_val = reload_q;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.rdy  = rdy_q;
  assign bus.tick = tick_q;
`ifdef TMR_READBACK_EN
  assign bus.cnt_q = cnt;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl; expiry times modelled as absolute edge numbers.
// Checks cnt_q too when TMR_READBACK_EN is defined.
module tb_timer_ctrl;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 48;

  typedef struct {
    logic             rdy;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    longint           edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  timer_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SCALE_STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint edge_no = 0;

  // Reference model: a running timer is an absolute edge at which it next expires.
  bit     m_run = 0;
  bit     m_per = 0;
  longint m_exp = 0;
  longint m_period = 0;

  function automatic longint scaled_value(input logic [3:0] o, input logic [DATA_W-1:0] d);
    longint v;
    v = longint'(d) * (longint'(1) << (8 * int'(o[1:0])));
    return v & ((longint'(1) << CNT_W) - 1);
  endfunction

  task automatic step(input bit r, input bit c, input logic [3:0] o, input logic [DATA_W-1:0] d);
    exp_t   e;
    bit     t;
    bit     was_run;
    longint v;
    @(negedge clk);
    rst_n       = r;
    bus.cs      = c;
    bus.op      = o;
    bus.data_in = d;
    edge_no++;
    if (!r) begin
      m_run = 0;
      m_per = 0;
      t     = 0;
    end else begin
      was_run = m_run;
      t = m_run && (edge_no == m_exp);
      if (t) begin
        if (m_per) m_exp += m_period;
        else       m_run = 0;
      end
      if (c && o[3]) begin
        if (was_run) begin
          t     = 0;
          m_run = 0;
          m_per = 0;
        end
      end else if (c) begin
        v        = scaled_value(o, d);
        m_run    = 1;
        m_per    = o[2];
        m_period = v + 1;
        m_exp    = edge_no + v + 1;
      end
    end
    e.rdy     = !m_run;
    e.tick    = t;
    e.cnt     = m_run ? CNT_W'(m_exp - 1 - edge_no) : '0;
    e.edge_no = edge_no;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'b0000, '0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rdy !== e.rdy) begin
        errors++;
        $display("FAIL rdy edge %0d: got %b expected %b", e.edge_no, bus.rdy, e.rdy);
      end
      checks++;
      if (bus.tick !== e.tick) begin
        errors++;
        $display("FAIL tick edge %0d: got %b expected %b", e.edge_no, bus.tick, e.tick);
      end
`ifdef TMR_READBACK_EN
      checks++;
      if (bus.cnt_q !== e.cnt) begin
        errors++;
        $display("FAIL cnt_q edge %0d: got %0d expected %0d", e.edge_no, bus.cnt_q, e.cnt);
      end
`endif
    end
  end

  initial begin
    logic [3:0]        o;
    logic [DATA_W-1:0] d;
    bus.cs = 1'b0;
    bus.op = 4'b0000;
    bus.data_in = '0;

    for (int i = 0; i < 3; i++) step(0, 0, 4'b0000, '0);
    idle(20);

    step(1, 1, 4'b0000, 24'd5);
    idle(8);
    step(1, 1, 4'b0001, 24'd2);
    idle(520);
    step(1, 1, 4'b0000, 24'd0);
    idle(3);

    step(1, 1, 4'b0100, 24'd3);
    idle(14);
    step(1, 1, 4'b1000, 24'd7);
    idle(4);
    step(1, 1, 4'b1000, 24'd7);
    idle(2);

    step(1, 1, 4'b0000, 24'd10);
    idle(3);
    step(1, 1, 4'b0000, 24'd2);
    idle(6);

    step(1, 1, 4'b0100, 24'd0);
    idle(5);
    step(1, 1, 4'b0000, 24'd4);
    idle(7);

    step(1, 1, 4'b0000, 24'd100);
    idle(49);
    step(0, 1, 4'b0000, 24'd9);
    #1;
    checks++;
    if (bus.rdy !== 1'b1 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b tick=%b expected rdy=1 tick=0", bus.rdy, bus.tick);
    end
`ifdef TMR_READBACK_EN
    checks++;
    if (bus.cnt_q !== '0) begin
      errors++;
      $display("FAIL async_reset_cnt: got %0d expected 0", bus.cnt_q);
    end
`endif
    step(0, 0, 4'b0000, '0);
    idle(5);

    for (int i = 0; i < 4000; i++) begin
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) o[1:0] = 2'b00;
      else if ($urandom_range(0, 3) != 0) o[1:0] = 2'b01;
      if ($urandom_range(0, 2) != 0) o[3] = 1'b0;
      d = DATA_W'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) step(0, 0, 4'b0000, '0);
      else step(1, ($urandom_range(0, 9) == 0), o, d);
    end
    idle(4);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
